// File: rtl/nibble_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sweep_gen
// Purpose  : Sweeps a 4-bit pattern {a,b,c,d} through 0..15 to exercise a
//            downstream 4-input XOR stage. Each pattern is held for
//            hold_cycles+1 clocks, and a registered expected XOR (parity_exp)
//            accompanies every pattern. The block supports a one-shot sweep
//            that ends with a done pulse, or a continuous looping sweep.
// Ports    :
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle request to begin a sweep (IDLE only)
//   stop         in   synchronous abort; wins over start
//   hold_cycles  in   extra cycles each pattern is held (latched at start)
//   loop         in   1 = repeat sweep continuously (latched at start)
//   a,b,c,d      out  pattern bits, a = MSB, d = LSB
//   valid        out  a,b,c,d carry a live pattern
//   parity_exp   out  registered a^b^c^d of the current pattern
//   busy         out  sweep in progress
//   done         out  one-cycle pulse at sweep completion
// Revision : 1.0 - initial release
// ============================================================================
module nibble_sweep_gen #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              loop,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              valid,
  output logic              parity_exp,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

  state_t            r_state;
  logic [3:0]        r_pat;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] r_hold_lat;
  logic              r_loop_lat;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_parity;

  logic              w_hold_end;
  logic              w_last_pat;
  logic [3:0]        w_pat_next;

  // The hold counter counts down from the latched hold value; reaching zero
  // marks the last cycle of the current pattern.
  assign w_hold_end = (r_hold_cnt == '0);
  assign w_last_pat = (r_pat == 4'hF);
  // Natural 4-bit wrap gives F -> 0 for the looping case.
  assign w_pat_next = r_pat + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pat      <= 4'h0;
      r_hold_cnt <= '0;
      r_hold_lat <= '0;
      r_loop_lat <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pat    <= 4'h0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_parity <= 1'b0;
          // stop has priority over a simultaneous start
          if (start && !stop) begin
            r_state    <= S_RUN;
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_hold_lat <= hold_cycles;
            r_loop_lat <= loop;
            r_hold_cnt <= hold_cycles;
          end
        end

        S_RUN: begin
          if (stop) begin
            r_state    <= S_IDLE;
            r_pat      <= 4'h0;
            r_parity   <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
          end else if (w_hold_end) begin
            r_hold_cnt <= r_hold_lat;
            if (w_last_pat && !r_loop_lat) begin
              r_state    <= S_DONE;
              r_pat      <= 4'h0;
              r_parity   <= 1'b0;
              r_valid    <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_hold_cnt <= '0;
            end else begin
              // Parity is computed from the next pattern so it changes on
              // the same edge as the pattern bits.
              r_pat    <= w_pat_next;
              r_parity <= ^w_pat_next;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - C_HOLD_ONE;
          end
        end

        S_DONE: begin
          // Single-cycle completion pulse; start here is ignored.
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_pat      <= 4'h0;
          r_hold_cnt <= '0;
          r_valid    <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_parity   <= 1'b0;
        end
      endcase
    end
  end

  assign a          = r_pat[3];
  assign b          = r_pat[2];
  assign c          = r_pat[1];
  assign d          = r_pat[0];
  assign valid      = r_valid;
  assign parity_exp = r_parity;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nibble_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_sweep_gen
// Purpose  : Self-checking bench for nibble_sweep_gen. Expected output
//            vectors {done,busy,valid,parity_exp,a,b,c,d} are queued as
//            stimulus is applied and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_sweep_gen;

  localparam int HOLD_W = 4;
  localparam logic [7:0] C_DONE_V = 8'h80;
  localparam logic [7:0] C_IDLE_V = 8'h00;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [HOLD_W-1:0] hold_cycles;
  logic              loop;
  logic              a, b, c, d;
  logic              valid, parity_exp, busy, done;

  // Downstream 4-input XOR stage
  logic              xor_out;
  assign xor_out = a ^ b ^ c ^ d;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];

  nibble_sweep_gen #(.HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .hold_cycles (hold_cycles),
    .loop        (loop),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .valid       (valid),
    .parity_exp  (parity_exp),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {done, busy, valid, parity_exp, a, b, c, d};
  endfunction

  // Expected live-pattern vector; parity from population count.
  function automatic logic [7:0] exp_pat(input logic [3:0] k);
    logic p;
    p = (($countones(k) % 2) == 1);
    return {1'b0, 1'b1, 1'b1, p, k};
  endfunction

  task automatic push_sweep(input int hold, input int first, input int last);
    for (int k = first; k <= last; k++)
      for (int r = 0; r <= hold; r++)
        sb_q.push_back(exp_pat(4'(k)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; hold_cycles = '0; loop = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== C_IDLE_V) begin
      n_fail++;
      $display("FAIL reset_async: got %h required %h", obs(), C_IDLE_V);
    end
    tick();
    n_checks++;
    if (obs() !== C_IDLE_V) begin
      n_fail++;
      $display("FAIL reset_hold: got %h required %h", obs(), C_IDLE_V);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs() !== C_IDLE_V) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %h required %h", i, obs(), C_IDLE_V);
      end
    end
  endtask

  // hold 0, loop 0; start also pulsed during DONE and must be ignored.
  task automatic test_sweep_h0();
    logic [7:0] e_vec;
    int idx = 0;
    hold_cycles = 4'd0; loop = 1'b0; start = 1'b1;
    push_sweep(0, 0, 15);
    sb_q.push_back(C_DONE_V);
    sb_q.push_back(C_IDLE_V);
    sb_q.push_back(C_IDLE_V);
    while (sb_q.size() > 0) begin
      tick();
      e_vec = sb_q.pop_front();
      n_checks++;
      if (obs() !== e_vec) begin
        n_fail++;
        $display("FAIL sweep_h0 idx %0d: got %h required %h", idx, obs(), e_vec);
      end
      if (valid) begin
        n_checks++;
        if (xor_out !== parity_exp) begin
          n_fail++;
          $display("FAIL xor_stage_h0 idx %0d: xor %b parity_exp %b", idx, xor_out, parity_exp);
        end
      end
      start = (e_vec == C_DONE_V);
      idx++;
    end
    start = 1'b0;
  endtask

  task automatic test_sweep_h1();
    logic [7:0] e_vec;
    int idx = 0;
    int n_valid = 0;
    int n_done = 0;
    hold_cycles = 4'd1; loop = 1'b0; start = 1'b1;
    push_sweep(1, 0, 15);
    sb_q.push_back(C_DONE_V);
    sb_q.push_back(C_IDLE_V);
    while (sb_q.size() > 0) begin
      tick();
      start = 1'b0;
      e_vec = sb_q.pop_front();
      if (valid === 1'b1) n_valid++;
      if (done === 1'b1) n_done++;
      n_checks++;
      if (obs() !== e_vec) begin
        n_fail++;
        $display("FAIL sweep_h1 idx %0d: got %h required %h", idx, obs(), e_vec);
      end
      if (valid) begin
        n_checks++;
        if (xor_out !== parity_exp) begin
          n_fail++;
          $display("FAIL xor_stage_h1 idx %0d: xor %b parity_exp %b", idx, xor_out, parity_exp);
        end
      end
      idx++;
    end
    n_checks++;
    if (n_valid != 32) begin
      n_fail++;
      $display("FAIL h1_valid_count: got %0d required 32", n_valid);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL h1_done_count: got %0d required 1", n_done);
    end
  endtask

  // Loop wrap F -> 0 without done, then stop during the second pattern 5.
  task automatic test_loop_stop();
    logic [7:0] e_vec;
    int idx = 0;
    hold_cycles = 4'd0; loop = 1'b1; start = 1'b1;
    push_sweep(0, 0, 15);
    push_sweep(0, 0, 5);
    sb_q.push_back(C_IDLE_V);
    sb_q.push_back(C_IDLE_V);
    while (sb_q.size() > 0) begin
      tick();
      start = 1'b0;
      loop  = 1'b0;  // latched value must still govern
      e_vec = sb_q.pop_front();
      n_checks++;
      if (obs() !== e_vec) begin
        n_fail++;
        $display("FAIL loop_stop idx %0d: got %h required %h", idx, obs(), e_vec);
      end
      stop = (idx == 21);
      idx++;
    end
    stop = 1'b0;
  endtask

  // Start re-pulsed and hold_cycles changed while running at pattern 7.
  task automatic test_restart_hold_change();
    logic [7:0] e_vec;
    int idx = 0;
    hold_cycles = 4'd1; loop = 1'b0; start = 1'b1;
    push_sweep(1, 0, 15);
    sb_q.push_back(C_DONE_V);
    sb_q.push_back(C_IDLE_V);
    while (sb_q.size() > 0) begin
      tick();
      start = 1'b0;
      e_vec = sb_q.pop_front();
      n_checks++;
      if (obs() !== e_vec) begin
        n_fail++;
        $display("FAIL restart_hold idx %0d: got %h required %h", idx, obs(), e_vec);
      end
      if (idx == 14) begin
        start = 1'b1;
        hold_cycles = 4'd3;
      end
      idx++;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e_vec;
    int idx = 0;
    hold_cycles = 4'd0; loop = 1'b0; start = 1'b1;
    push_sweep(0, 0, 10);
    while (sb_q.size() > 0) begin
      tick();
      start = 1'b0;
      e_vec = sb_q.pop_front();
      n_checks++;
      if (obs() !== e_vec) begin
        n_fail++;
        $display("FAIL async_pre idx %0d: got %h required %h", idx, obs(), e_vec);
      end
      idx++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== C_IDLE_V) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h required %h", obs(), C_IDLE_V);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs() !== C_IDLE_V) begin
        n_fail++;
        $display("FAIL async_post_idle cycle %0d: got %h required %h", i, obs(), C_IDLE_V);
      end
    end
    // New sweep restarts from pattern 0
    start = 1'b1;
    push_sweep(0, 0, 2);
    idx = 0;
    while (sb_q.size() > 0) begin
      tick();
      start = 1'b0;
      e_vec = sb_q.pop_front();
      n_checks++;
      if (obs() !== e_vec) begin
        n_fail++;
        $display("FAIL async_restart idx %0d: got %h required %h", idx, obs(), e_vec);
      end
      idx++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (obs() !== C_IDLE_V) begin
      n_fail++;
      $display("FAIL async_restart_stop: got %h required %h", obs(), C_IDLE_V);
    end
  endtask

  task automatic test_start_stop_same();
    start = 1'b1; stop = 1'b1; hold_cycles = 4'd0; loop = 1'b0;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs() !== C_IDLE_V) begin
        n_fail++;
        $display("FAIL start_stop_same cycle %0d: got %h required %h", i, obs(), C_IDLE_V);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sweep_h0();
    test_sweep_h1();
    test_loop_stop();
    test_restart_hold_change();
    test_async_reset();
    test_start_stop_same();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/nibble_sweep_gen.md
NIBBLE_SWEEP_GEN -- requirements
Module: nibble_sweep_gen

Interface
REQ-001 SHALL have parameter HOLD_W, default 4, width of the per-pattern hold count.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port stop  input  1  synchronous abort of a sweep.
REQ-006 SHALL have port hold_cycles  input  HOLD_W  extra cycles each pattern is held.
REQ-007 SHALL have port loop  input  1  repeat sweep continuously when 1.
REQ-008 SHALL have ports a, b, c, d  output  1 each  pattern bits to downstream 4-input XOR stage; {a,b,c,d} forms a 4-bit count, a = MSB, d = LSB.
REQ-009 SHALL have port valid  output  1  a,b,c,d carry a live pattern.
REQ-010 SHALL have port parity_exp  output  1  registered a^b^c^d, the expected XOR of the current pattern.
REQ-011 SHALL have port busy  output  1  sweep in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at sweep completion.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 In IDLE, start=1 and stop=0 SHALL at the next edge enter RUN with {a,b,c,d}=4'h0, valid=1, busy=1, parity_exp=0.
REQ-015 hold_cycles and loop SHALL be latched at the start edge; later changes have no effect on the current sweep.
REQ-016 Each pattern SHALL be held for exactly hold_cycles+1 clock cycles (hold_cycles=0 gives one cycle per pattern); an internal hold counter of HOLD_W bits counts the hold.
REQ-017 At the end of a pattern's hold, {a,b,c,d} SHALL increment by 1 and the hold counter SHALL reload.
REQ-018 parity_exp SHALL update on the same edge as a,b,c,d so both always describe the same pattern.
REQ-019 At the end of pattern 4'hF with latched loop=1, {a,b,c,d} SHALL wrap to 4'h0 and the FSM SHALL stay in RUN; done SHALL not assert.
REQ-020 At the end of pattern 4'hF with latched loop=0, the FSM SHALL enter DONE: valid=0, busy=0, done=1, and {a,b,c,d}=4'h0.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE with done=0.
REQ-022 start asserted in RUN or DONE SHALL be ignored.
REQ-023 stop=1 in RUN SHALL at the next edge enter IDLE with {a,b,c,d}=0, valid=0, busy=0, and no done pulse.
REQ-024 Simultaneous start and stop in IDLE SHALL leave the FSM in IDLE, because stop has priority.
REQ-025 In IDLE, valid=0, busy=0, done=0, and {a,b,c,d}=0 SHALL be held.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, a=b=c=d=0, valid=0, parity_exp=0, busy=0, done=0, and clear the hold counter and latched settings.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after rst_n deasserts, a new start SHALL begin again from 4'h0.

Verification
REQ-028 The bench SHALL cover this scenario: hold_cycles=0, loop=0, start pulse at edge N -> {a,b,c,d} = 0..15 on edges N+1..N+16, parity_exp = 0,1,1,0,1,0,0,1,... (popcount parity), done=1 only at edge N+17, IDLE at N+18.
REQ-029 The bench SHALL cover this scenario: hold_cycles=1, loop=0 -> each pattern stable 2 cycles, 32 valid cycles total, single done pulse after pattern 4'hF.
REQ-030 The bench SHALL cover this scenario: hold_cycles=0, loop=1 -> pattern 4'hF followed directly by 4'h0 with valid held at 1 and no done; stop during pattern 4'h5 -> IDLE at next edge, valid=0, no done.
REQ-031 The bench SHALL cover this scenario: start re-pulsed during RUN at pattern 4'h7 -> sequence continues 4'h8, 4'h9 unaffected; hold_cycles changed mid-sweep -> hold length unchanged.
REQ-032 The bench SHALL cover this scenario: rst_n driven low between clock edges at pattern 4'hA -> all outputs 0 immediately; after release with no start, the block stays idle.
REQ-033 The bench SHALL cover this scenario: start=1 and stop=1 in the same cycle in IDLE -> busy stays 0.
REQ-034 The bench SHALL cover this scenario: downstream 4-input XOR stage connected, every valid cycle -> its full-XOR output equals parity_exp.
